// File: rtl/sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sram_responder                                                   |
// | Purpose : Behavioural-synthesizable model of a 16-bit external async SRAM  |
// |           with byte lanes, 1-cycle registered reads and a preload port.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sram_responder #(
  parameter int ADDR_WIDTH = 18,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 4096,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  wre,
  input  logic                  oute,
  input  logic                  hb_mask,
  input  logic                  lb_mask,
  input  logic                  chip_en,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic [CNT_WIDTH-1:0]  wr_count,
  output logic                  oob_err
);

  localparam int                  c_IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                  c_LANE_W  = DATA_WIDTH / 2;
  localparam logic [ADDR_WIDTH:0] c_DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic [CNT_WIDTH-1:0]  r_rd_cnt;
  logic [CNT_WIDTH-1:0]  r_wr_cnt;
  logic                  r_oob;

  logic                  w_wr;
  logic                  w_rd;
  logic                  w_addr_ok;
  logic                  w_load_ok;
  logic                  w_load_fire;
  logic [c_IDX_W-1:0]    w_idx;
  logic [c_IDX_W-1:0]    w_load_idx;
  logic                  w_drv_ok;
  logic [1:0]            w_lane_n;

  assign w_wr        = ~chip_en & ~wre;
  assign w_rd        = ~chip_en & wre & ~oute;
  assign w_addr_ok   = ({1'b0, addr} < c_DEPTH_X);
  assign w_load_ok   = ({1'b0, load_addr} < c_DEPTH_X);
  assign w_idx       = addr[c_IDX_W-1:0];
  assign w_load_idx  = load_addr[c_IDX_W-1:0];

  // Preload is only accepted while the controller has the chip deselected,
  // so it can never collide with a controller write.
  assign load_ready  = chip_en;
  assign w_load_fire = load_valid & chip_en;

  always_ff @(posedge clock) begin
    if (w_load_fire && w_load_ok) begin
      r_mem[w_load_idx] <= load_data;
    end else if (w_wr && w_addr_ok) begin
      if (!hb_mask) r_mem[w_idx][DATA_WIDTH-1:c_LANE_W] <= data[DATA_WIDTH-1:c_LANE_W];
      if (!lb_mask) r_mem[w_idx][c_LANE_W-1:0]          <= data[c_LANE_W-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_cnt   <= '0;
      r_wr_cnt   <= '0;
      r_oob      <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;
      if (w_rd) begin
        r_rd_data <= w_addr_ok ? r_mem[w_idx] : '0;
        if (r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + CNT_WIDTH'(1);
      end
      if (w_wr && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + CNT_WIDTH'(1);
      end
      if (((w_rd || w_wr) && !w_addr_ok) || (w_load_fire && !w_load_ok)) begin
        r_oob <= 1'b1;
      end
    end
  end

  assign rd_count = r_rd_cnt;
  assign wr_count = r_wr_cnt;
  assign oob_err  = r_oob;

  // Drive enables use live pins so the bus is released in the same cycle
  // the controller turns it around.
  assign w_drv_ok = reset & r_rd_valid & ~chip_en & ~oute & wre;
  assign w_lane_n = {hb_mask, lb_mask};

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign data[gi*c_LANE_W +: c_LANE_W] = (w_drv_ok && !w_lane_n[gi])
                                           ? r_rd_data[gi*c_LANE_W +: c_LANE_W]
                                           : {c_LANE_W{1'bz}};
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sram_responder                                                |
// | Purpose : Directed + randomized self-checking bench for sram_responder.    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sram_responder;

  localparam int AW    = 18;
  localparam int DW    = 16;
  localparam int DEPTH = 4096;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;
  localparam int NW    = 128;

  logic          clock      = 1'b0;
  logic          rst_n      = 1'b0;
  logic [AW-1:0] addr       = '0;
  wire  [DW-1:0] data;
  logic          wre        = 1'b1;
  logic          oute       = 1'b1;
  logic          hb_mask    = 1'b1;
  logic          lb_mask    = 1'b1;
  logic          chip_en    = 1'b1;
  logic          load_valid = 1'b0;
  logic          load_ready;
  logic [AW-1:0] load_addr  = '0;
  logic [DW-1:0] load_data  = '0;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] wr_count;
  logic          oob_err;

  logic          drv_en  = 1'b0;
  logic [DW-1:0] drv_val = '0;

  int total = 0;
  int bad   = 0;

  // Reference state: word contents, saturating counts, sticky error.
  logic [DW-1:0] m [NW];
  int            m_rd  = 0;
  int            m_wr  = 0;
  logic          m_oob = 1'b0;

  assign data = drv_en ? drv_val : {DW{1'bz}};

  // Released lanes float up to all-ones, so an undriven lane reads 8'hFF.
  for (genvar i = 0; i < DW; i++) begin : g_pu
    pullup (data[i]);
  end

  sram_responder #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock), .reset(rst_n), .addr(addr), .data(data), .wre(wre),
    .oute(oute), .hb_mask(hb_mask), .lb_mask(lb_mask), .chip_en(chip_en),
    .load_valid(load_valid), .load_ready(load_ready), .load_addr(load_addr),
    .load_data(load_data), .rd_count(rd_count), .wr_count(wr_count),
    .oob_err(oob_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] rnd16();
    return 16'($urandom) & 16'hFEFE;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic chk_status();
    chk("rd_count", 16'(rd_count), 16'(m_rd));
    chk("wr_count", 16'(wr_count), 16'(m_wr));
    chk("oob_err",  16'(oob_err),  16'(m_oob));
  endtask

  task automatic op_load(input int a, input logic [15:0] d);
    chip_en = 1'b1; wre = 1'b1; oute = 1'b1; drv_en = 1'b0;
    load_valid = 1'b1; load_addr = AW'(a); load_data = d;
    #1 chk("ld_ready_hi", 16'(load_ready), 16'd1);
    tick();
    load_valid = 1'b0;
    if (a < NW) m[a] = d;
    else if (a >= DEPTH) m_oob = 1'b1;
    chk_status();
  endtask

  task automatic op_write(input int a, input logic [15:0] d, input logic hb, input logic lb, input logic oe);
    chip_en = 1'b0; wre = 1'b0; oute = oe; hb_mask = hb; lb_mask = lb;
    addr = AW'(a); load_valid = 1'b0; drv_en = 1'b1; drv_val = d;
    #1 chk("wr_bus_clean", data, d);
    tick();
    drv_en = 1'b0;
    m_wr = sat(m_wr);
    if (a >= DEPTH) m_oob = 1'b1;
    else begin
      if (!hb) m[a][15:8] = d[15:8];
      if (!lb) m[a][7:0]  = d[7:0];
    end
    chk_status();
  endtask

  task automatic op_read(input int a, input logic hb, input logic lb);
    logic [15:0] v;
    logic [15:0] e;
    chip_en = 1'b0; wre = 1'b1; oute = 1'b0; hb_mask = hb; lb_mask = lb;
    addr = AW'(a); load_valid = 1'b0; drv_en = 1'b0;
    tick();
    v = (a >= DEPTH) ? 16'h0000 : m[a];
    e = {hb ? 8'hFF : v[15:8], lb ? 8'hFF : v[7:0]};
    chk("rd_data", data, e);
    m_rd = sat(m_rd);
    if (a >= DEPTH) m_oob = 1'b1;
    chk_status();
  endtask

  task automatic op_idle();
    chip_en = 1'b0; wre = 1'b1; oute = 1'b1; load_valid = 1'b0; drv_en = 1'b0;
    tick();
    chk("idle_bus", data, 16'hFFFF);
    chk_status();
  endtask

  task automatic op_desel();
    chip_en = 1'b1; wre = 1'b1; oute = 1'b0; load_valid = 1'b0; drv_en = 1'b0;
    tick();
    chk("desel_bus", data, 16'hFFFF);
    chk("desel_ready", 16'(load_ready), 16'd1);
    chk_status();
  endtask

  initial begin
    #1;
    chk("rst_bus", data, 16'hFFFF);
    chk_status();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < NW; i++) op_load(i, rnd16());

    // Preload then read back with one-cycle latency.
    op_load(16'h0010, 16'hBEEF);
    op_load(16'h0011, 16'h1234);
    op_read(16'h0010, 1'b0, 1'b0);
    op_read(16'h0011, 1'b0, 1'b0);
    chk("rd_count_two", 16'(rd_count), 16'd2);

    // Byte-lane write and masked read.
    op_load(16'h0020, 16'hAAAA);
    op_write(16'h0020, 16'h5566, 1'b1, 1'b0, 1'b1);
    op_read(16'h0020, 1'b0, 1'b0);
    chk("byte_merge", data, 16'hAA66);
    chk("wr_count_one", 16'(wr_count), 16'd1);
    op_read(16'h0020, 1'b0, 1'b1);

    // Read/write/read turnaround with no idle gap.
    op_read(16'h0010, 1'b0, 1'b0);
    op_write(16'h0030, 16'h0F0F, 1'b0, 1'b0, 1'b0);
    op_read(16'h0030, 1'b0, 1'b0);
    chk("turnaround_rd", data, 16'h0F0F);

    // Out-of-range: aliases of in-range words must stay untouched.
    op_read(DEPTH, 1'b0, 1'b0);
    op_write(DEPTH + 16'h0020, 16'h1111, 1'b0, 1'b0, 1'b1);
    op_read(16'h0020, 1'b0, 1'b0);

    // Preload held across a deselect window.
    op_load(16'h0041, 16'h2468);
    load_valid = 1'b1; load_addr = AW'(16'h0040); load_data = 16'hC0DE;
    chip_en = 1'b0; wre = 1'b1; oute = 1'b0; hb_mask = 1'b0; lb_mask = 1'b0;
    addr = AW'(16'h0040);
    for (int k = 0; k < 2; k++) begin
      #1 chk("stall_ready_lo", 16'(load_ready), 16'd0);
      tick();
      m_rd = sat(m_rd);
      chk("stall_no_write", data, m[16'h0040]);
    end
    chip_en = 1'b1;
    #1 chk("stall_ready_hi", 16'(load_ready), 16'd1);
    tick();
    load_valid = 1'b0;
    m[16'h0040] = 16'hC0DE;
    chk_status();
    op_desel();
    op_read(16'h0040, 1'b0, 1'b0);
    op_write(16'h0040, 16'h2222, 1'b0, 1'b0, 1'b1);
    op_desel();
    op_desel();
    op_read(16'h0040, 1'b0, 1'b0);

    // Random traffic against the reference model; counters saturate here.
    for (int n = 0; n < 400; n++) begin
      int sel;
      int a;
      sel = $urandom_range(0, 9);
      a   = $urandom_range(0, NW - 1);
      case (sel)
        0, 1, 2: op_write(a, rnd16(), 1'($urandom), 1'($urandom), 1'($urandom));
        3, 4, 5: op_read(a, 1'($urandom), 1'($urandom));
        6:       op_load(a, rnd16());
        7:       op_idle();
        8:       op_desel();
        default: begin
          if ($urandom_range(0, 1) == 0) op_read(DEPTH + $urandom_range(0, 2000), 1'b0, 1'b0);
          else op_write(DEPTH + $urandom_range(0, 2000), rnd16(), 1'b0, 1'b0, 1'b1);
        end
      endcase
    end

    // Reset while the bus is being driven.
    op_load(16'h0010, 16'hBEEF);
    op_read(16'h0010, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    m_rd = 0; m_wr = 0; m_oob = 1'b0;
    #1 chk("rst_release_bus", data, 16'hFFFF);
    chk_status();
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_no_drive", data, 16'hFFFF);
    op_read(16'h0010, 1'b0, 1'b0);
    chk("post_rst_mem", data, 16'hBEEF);

    op_load(DEPTH + 1, 16'h1234);
    op_read(1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_responder.md
Name: sram_responder

Overview:
- Synthesizable single-clock model of the external 16-bit SRAM device behind the memory controller's RAM pins: addr[17:0], data[15:0] inout, wre, oute, hb_mask, lb_mask, chip_en.
- Serves the controller's requests with byte-lane masking, one-cycle registered read data and bus tristating.
- Provides a valid/ready preload port so a bench or boot loader can fill program memory while the chip is deselected.
- Keeps saturating access counters and a sticky out-of-range flag for verification.

Parameters:
- ADDR_WIDTH, 18, width of addr.
- DATA_WIDTH, 16, width of data; must be 16 (two byte lanes).
- DEPTH, 4096, number of implemented 16-bit words; addresses >= DEPTH are out of range.
- CNT_WIDTH, 16, width of each access counter.

Ports:
- clock  input  1  system clock; all sampling on posedge.
- reset  input  1  asynchronous, active-low reset.
- addr  input  ADDR_WIDTH  word address from controller.
- data  inout  DATA_WIDTH  bidirectional data bus.
- wre  input  1  write enable, active low.
- oute  input  1  output enable, active low.
- hb_mask  input  1  high byte lane [15:8] enable, active low.
- lb_mask  input  1  low byte lane [7:0] enable, active low.
- chip_en  input  1  chip select, active low.
- load_valid  input  1  preload request.
- load_ready  output  1  preload accepted this cycle when high with load_valid.
- load_addr  input  ADDR_WIDTH  preload word address.
- load_data  input  DATA_WIDTH  preload word.
- rd_count  output  CNT_WIDTH  completed read captures, saturating.
- wr_count  output  CNT_WIDTH  completed writes, saturating.
- oob_err  output  1  sticky: an access or preload targeted addr >= DEPTH.

Behaviour:
- Reset (reset=0, asynchronous): rd_data_q=0, rd_valid_q=0, rd_count=0, wr_count=0, oob_err=0; data goes high-Z immediately. The memory array is NOT cleared.
- Cycle classification at posedge, while chip_en=0:
  - WRITE: wre=0. Write each enabled lane (hb_mask=0 -> [15:8], lb_mask=0 -> [7:0]) of mem[addr] from data. wr_count+1, even if both lanes are masked. oute is ignored.
  - READ: wre=1 and oute=0. rd_data_q <= mem[addr]; rd_valid_q <= 1; rd_count+1.
  - IDLE: wre=1 and oute=1. rd_valid_q <= 0.
- chip_en=1 at posedge: rd_valid_q <= 0; no array access.
- Read latency is 1 cycle. Data addressed at posedge N is driven after posedge N until posedge N+1.
- Bus drive:
  - Lane [15:8] = rd_data_q[15:8] iff rd_valid_q & ~chip_en & ~oute & wre & ~hb_mask; else Z.
  - Lane [7:0] follows the same rule with lb_mask.
  - The drive-enable terms use live pins, so deasserting oute, chip_en or wre releases the bus the same cycle (no contention on write turnaround).
- Write then read of the same address in consecutive cycles returns the new data.
- Out of range (addr >= DEPTH):
  - Write is ignored but still counted.
  - Read captures 16'h0000 and still sets rd_valid_q.
  - oob_err <= 1; cleared only by reset.
- Preload:
  - load_ready = chip_en (combinational).
  - Transfer when load_valid & load_ready at posedge: mem[load_addr] <= load_data, full word, no masks. Counters unaffected.
  - Out-of-range load_addr: write dropped, oob_err set.
  - If chip_en falls while load_valid is held, load_ready drops and the load stalls until chip_en=1. No load is lost or duplicated.
- Counters saturate at all-ones and do not wrap.
- Reset asserted mid-read: bus released asynchronously. After release, the first read needs a new READ cycle before it drives.

Test Plan:
- Preload: chip_en=1, load 0x0010=16'hBEEF, 0x0011=16'h1234. Then chip_en=0, oute=0, wre=1, addr=0x0010. Next cycle data=16'hBEEF; addr=0x0011 gives 16'h1234 one cycle later. rd_count=2.
- Byte write: mem[0x20]=16'hAAAA; write data=16'h5566 with hb_mask=1, lb_mask=0. Read back 16'hAA66, wr_count=1. Read with lb_mask=1: data=16'hAAzz.
- Turnaround: alternate READ 0x10 / WRITE 0x30=16'h0F0F / READ 0x30. No cycle has both the bench and the DUT driving the same lane. Final read returns 16'h0F0F.
- Out of range: READ addr=4096 -> 16'h0000, oob_err=1. WRITE addr=5000 -> no array change, wr_count increments. Preload to 4097 -> dropped.
- Preload stall: hold load_valid with addr 0x40=16'hC0DE while chip_en toggles 1,0,0,1. Exactly one write occurs, on the final chip_en=1 cycle. A later read returns 16'hC0DE.
- Reset mid-read: assert reset during a driving cycle. data becomes Z within the same cycle; counters and oob_err=0. mem[0x10] still reads 16'hBEEF after reset.
